usreg_sipo_rx: RTL and testbench

//  Serial-to-parallel receiver: the receiving end of the serial link driven by
//  the universal shift register's shift-out modes. Collects WIDTH bits, one per
//  ser_valid strobe, MSB- or LSB-first, framed by ser_first. Presents each word
//  on a one-deep valid/ready output buffer. Flags overrun and framing errors.

---
 rtl/usreg_sipo_rx.sv | 173 +++++++++++++++++
 tb/tb_usreg_sipo_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usreg_sipo_rx.sv
// usreg_sipo_rx: serial-to-parallel receiver with a one-deep valid/ready output buffer.
// Define PARITY_CHECK_EN to expect one trailing even-parity bit per word.
module usreg_sipo_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             ser_valid,
    input  logic             ser_first,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             par_err,
    output logic             overrun,
    output logic             frame_err
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_lsb;
    logic             w_lsb_nxt;
    logic             w_lsb_eff;
    logic             w_start;
    logic             w_done;
    logic             w_frame;
    logic             r_done;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;
    logic             r_frame_err;
`ifdef PARITY_CHECK_EN
    logic             w_par;
    logic             r_par_pend;
    logic             r_par_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_lsb_nxt   = r_lsb;
        w_done      = 1'b0;
        w_frame     = 1'b0;
`ifdef PARITY_CHECK_EN
        w_par       = 1'b0;
`endif
        w_start     = ser_valid & ser_first;
        // A new word shifts into a cleared register using the direction sampled with its first bit.
        w_lsb_eff   = w_start ? lsb_first : r_lsb;
        w_base      = w_start ? '0 : r_sh;
        w_shifted   = w_lsb_eff ? {serial_in, w_base[WIDTH-1:1]}
                                : {w_base[WIDTH-2:0], serial_in};

        if (w_start) begin
            w_frame     = (r_state != ST_IDLE);
            w_state_nxt = ST_SHIFT;
            w_sh_nxt    = w_shifted;
            w_cnt_nxt   = CW'(1);
            w_lsb_nxt   = lsb_first;
        end else if (ser_valid) begin
            case (r_state)
                ST_SHIFT: begin
                    w_sh_nxt  = w_shifted;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PARITY: begin
                    w_done      = 1'b1;
                    w_par       = ^{r_sh, serial_in};
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh        <= '0;
            r_cnt       <= '0;
            r_lsb       <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_pend  <= 1'b0;
`endif
        end else begin
            r_sh        <= w_sh_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lsb       <= w_lsb_nxt;
            r_done      <= w_done;
            r_frame_err <= w_frame;
`ifdef PARITY_CHECK_EN
            r_par_pend  <= w_par;
`endif
        end
    end

    // r_sh still holds the completed word during the cycle r_done is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_dout_valid || dout_ready) begin
                    r_dout       <= r_sh;
                    r_dout_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                    r_par_err    <= r_par_pend;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
                r_par_err    <= 1'b0;
`endif
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
`ifdef PARITY_CHECK_EN
    assign par_err    = r_par_err;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_usreg_sipo_rx.sv
// Self-checking bench for usreg_sipo_rx: bit-list reference model compared every cycle,
// plus directed scenarios with literal expected values.
module tb_usreg_sipo_rx;
    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk;
    logic         rst;
    logic         serial_in;
    logic         ser_valid;
    logic         ser_first;
    logic         lsb_first;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         par_err;
    logic         overrun;
    logic         frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    usreg_sipo_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .ser_valid  (ser_valid),
        .ser_first  (ser_first),
        .lsb_first  (lsb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .par_err    (par_err),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the received bits of the current word as a list,
    // builds the word by bit position, and delivers it to the buffer one cycle later.
    int unsigned  m_n;
    logic         m_in;
    logic         m_lsb;
    logic [NB-1:0] m_bits;
    logic         m_pend;
    logic [W-1:0] m_pend_word;
    logic         m_pend_par;
    logic [W-1:0] exp_dout;
    logic         exp_valid;
    logic         exp_par;
    logic         exp_ovr;
    logic         exp_fe;

    function automatic logic [W-1:0] assemble(input logic [NB-1:0] bits, input logic lsb);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++)
            if (((bits >> i) & NB'(1)) != '0)
                w = w | (W'(1) << (lsb ? i : W - 1 - i));
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int unsigned   n;
        logic          inw;
        logic          lsb;
        logic          done;
        logic          ovr;
        logic [NB-1:0] bits;
        if (rst) begin
            m_n <= 0; m_in <= 1'b0; m_lsb <= 1'b0; m_bits <= '0;
            m_pend <= 1'b0; m_pend_word <= '0; m_pend_par <= 1'b0;
            exp_dout <= '0; exp_valid <= 1'b0; exp_par <= 1'b0;
            exp_ovr <= 1'b0; exp_fe <= 1'b0;
        end else begin
            n = m_n; inw = m_in; lsb = m_lsb; bits = m_bits; done = 1'b0; ovr = 1'b0;
            exp_fe <= ser_valid && ser_first && m_in;
            if (ser_valid && ser_first) begin
                inw = 1'b1; lsb = lsb_first; n = 0; bits = '0;
            end
            if (ser_valid && inw) begin
                bits = bits | (NB'(serial_in) << n);
                n = n + 1;
                if (n == NB) begin
                    done = 1'b1; inw = 1'b0; n = 0;
                end
            end
            if (m_pend) begin
                if (!exp_valid || dout_ready) begin
                    exp_dout <= m_pend_word; exp_valid <= 1'b1; exp_par <= m_pend_par;
                end else begin
                    ovr = 1'b1;
                end
            end else if (exp_valid && dout_ready) begin
                exp_valid <= 1'b0; exp_par <= 1'b0;
            end
            exp_ovr     <= ovr;
            m_n         <= n;
            m_in        <= inw;
            m_lsb       <= lsb;
            m_bits      <= bits;
            m_pend      <= done;
            m_pend_word <= assemble(bits, lsb);
`ifdef PARITY_CHECK_EN
            m_pend_par  <= ^bits;
`else
            m_pend_par  <= 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        chk("dout",       32'(dout),  32'(exp_dout));
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
        chk("par_err",    32'(par_err),    32'(exp_par));
        chk("overrun",    32'(overrun),    32'(exp_ovr));
        chk("frame_err",  32'(frame_err),  32'(exp_fe));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic first, input logic lsb);
        serial_in = b; ser_valid = 1'b1; ser_first = first; lsb_first = lsb;
        tick();
        ser_valid = 1'b0; ser_first = 1'b0;
    endtask

    // seq is given in transmission order: seq[W-1] goes first
    task automatic send_word(input logic [W-1:0] seq, input logic lsb);
        logic [W-1:0] s;
        s = seq;
        for (int i = 0; i < W; i++) begin
            send_bit(s[W-1], i == 0, lsb);
            s = s << 1;
        end
`ifdef PARITY_CHECK_EN
        send_bit(^seq, 1'b0, lsb);
`endif
    endtask

    initial begin
        rst = 1'b1; serial_in = 1'b0; ser_valid = 1'b0; ser_first = 1'b0;
        lsb_first = 1'b0; dout_ready = 1'b0;
        tick();
        tick();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_flags", 32'({par_err, overrun, frame_err}), 32'h0);
        rst = 1'b0;
        tick();

        // 1: MSB-first 1,0,1,1; stray strobe without ser_first is ignored
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        send_word(4'b1011, 1'b0);
        chk("t1_valid_lat", 32'(dout_valid), 32'h0);
        tick();
        chk("t1_dout", 32'(dout), 32'hB);
        chk("t1_valid", 32'(dout_valid), 32'h1);
        tick();
        chk("t1_valid_fall", 32'(dout_valid), 32'h0);

        // 2: LSB-first 1,0,1,1 with lsb_first toggled after bit 1
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
`ifdef PARITY_CHECK_EN
        send_bit(1'b1, 1'b0, 1'b0);
`endif
        tick();
        chk("t2_dout", 32'(dout), 32'hD);
        tick();

        // 3: A held, B overruns, then A consumed
        dout_ready = 1'b0;
        send_word(4'hA, 1'b0);
        tick();
        chk("t3_hold", 32'(dout), 32'hA);
        send_word(4'b0101, 1'b0);
        tick();
        chk("t3_overrun", 32'(overrun), 32'h1);
        chk("t3_dout_kept", 32'(dout), 32'hA);
        dout_ready = 1'b1;
        tick();
        chk("t3_consumed", 32'(dout_valid), 32'h0);
        chk("t3_ovr_pulse", 32'(overrun), 32'h0);

        // 3b: handshake coincides with completion of the next word
        dout_ready = 1'b0;
        send_word(4'hA, 1'b0);
        tick();
        send_word(4'b0011, 1'b0);
        dout_ready = 1'b1;
        tick();
        chk("t3b_dout", 32'(dout), 32'h3);
        chk("t3b_valid", 32'(dout_valid), 32'h1);
        chk("t3b_no_ovr", 32'(overrun), 32'h0);
        tick();

        // 4: ser_first after two bits restarts the word
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        chk("t4_frame_err", 32'(frame_err), 32'h1);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("t4_fe_pulse", 32'(frame_err), 32'h0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
        send_bit(1'b0, 1'b0, 1'b0);
`endif
        tick();
        chk("t4_dout", 32'(dout), 32'h6);

        // back-to-back words at full rate
        send_word(4'b1100, 1'b0);
        send_word(4'b0011, 1'b1);
        tick();
        chk("b2b_dout", 32'(dout), 32'hC);
        tick();

        // 5: async reset mid-word with a buffered word
        dout_ready = 1'b0;
        send_word(4'b1001, 1'b0);
        tick();
        chk("t5_buffered", 32'(dout_valid), 32'h1);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_dout", 32'(dout), 32'h0);
        chk("t5_rst_valid", 32'(dout_valid), 32'h0);
        chk("t5_rst_flags", 32'({par_err, overrun, frame_err}), 32'h0);
        #2 rst = 1'b0;
        tick();
        dout_ready = 1'b1;
        send_word(4'b0110, 1'b0);
        tick();
        chk("t5_after_dout", 32'(dout), 32'h6);
        chk("t5_after_valid", 32'(dout_valid), 32'h1);
        tick();

`ifdef PARITY_CHECK_EN
        // 6: explicit parity bits
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        tick();
        chk("t6_par_ok", 32'(par_err), 32'h0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        tick();
        chk("t6_par_bad", 32'(par_err), 32'h1);
        chk("t6_dout", 32'(dout), 32'hB);
        tick();
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
